// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: synchronizes and debounces four buttons, queues the last press and commits it on each move tick.
// Commit lands on the same edge that raises MOVE_TICK; there is no backpressure, and a newer press overwrites an unconsumed one.
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 25000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_LEFT,
    input  logic       BTN_RIGHT,
    input  logic       ENABLE,
    output logic       MOVE_TICK,
    output logic [1:0] DIR
);

    localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TKW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TKW-1:0] TK_LAST   = TKW'(TICK_DIV - 1);
    localparam logic [1:0]     DIR_RIGHT = 2'b11;

    // Bit index equals the direction code: 0 up, 1 down, 2 left, 3 right.
    logic [3:0] btn_raw;
    assign btn_raw = {BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

    logic [3:0]           sync1_q, sync2_q;
    logic [3:0]           lvl_q, lvl_d, lvl_prev_q;
    logic [3:0][DBW-1:0]  db_cnt_q, db_cnt_d;
    logic [TKW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                 tick_q, tick_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [1:0]           pend_code_q, pend_code_d;
    logic [1:0]           dir_q, dir_d;

    logic [3:0] press;
    logic       evt_vld;
    logic [1:0] evt_code;
    logic       req_vld;
    logic [1:0] req_code;
    logic       tick_last;

    always_comb begin
        lvl_d    = lvl_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press   = lvl_q & ~lvl_prev_q;
    assign evt_vld = |press;

    always_comb begin
        evt_code = 2'b11;
        if (press[0]) begin
            evt_code = 2'b00;
        end else if (press[1]) begin
            evt_code = 2'b01;
        end else if (press[2]) begin
            evt_code = 2'b10;
        end
    end

    assign tick_last = (tick_cnt_q == TK_LAST);

    always_comb begin
        tick_d     = ENABLE & tick_last;
        tick_cnt_d = '0;
        if (ENABLE && !tick_last) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    // A press arriving right before the commit edge outranks the stored one.
    assign req_vld  = evt_vld | pend_vld_q;
    assign req_code = evt_vld ? evt_code : pend_code_q;

    always_comb begin
        dir_d       = dir_q;
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        if (tick_d) begin
            pend_vld_d = 1'b0;
            if (req_vld && (req_code != (dir_q ^ 2'b01))) begin
                dir_d = req_code;
            end
        end else if (evt_vld) begin
            pend_vld_d  = 1'b1;
            pend_code_d = evt_code;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            lvl_q       <= '0;
            lvl_prev_q  <= '0;
            db_cnt_q    <= '0;
            tick_cnt_q  <= '0;
            tick_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_code_q <= '0;
            dir_q       <= DIR_RIGHT;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            lvl_q       <= lvl_d;
            lvl_prev_q  <= lvl_q;
            db_cnt_q    <= db_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_q      <= tick_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
            dir_q       <= dir_d;
        end
    end

    assign MOVE_TICK = tick_q;
    assign DIR       = dir_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random button traffic, scored against a cycle-level behavioural model.
module tb_snake_dir_ctrl;

    localparam int DB = 4;
    localparam int TD = 8;

    logic       clk;
    logic       reset;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       enable;
    logic       move_tick;
    logic [1:0] dir;

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
        .CLK(clk), .RESET(reset),
        .BTN_UP(btn_up), .BTN_DOWN(btn_down), .BTN_LEFT(btn_left), .BTN_RIGHT(btn_right),
        .ENABLE(enable), .MOVE_TICK(move_tick), .DIR(dir)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;
    bit mon_on  = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: a button level flips once its last DB synchronized samples all disagree with it;
    // ticks fall on every TD-th consecutive enabled cycle; the committed direction is queued for the monitor.
    bit m_s1[4], m_s2[4], m_lvl[4], m_lvl_prev[4];
    bit m_win[4][DB];
    int m_fill[4];
    int m_en_run = 0;
    bit m_pend_v = 0;
    int m_pend_c = 0;
    int m_dir    = 3;
    int exp_q[$];

    function automatic bit opposite(input int a, input int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    always @(posedge clk) begin
        bit raw[4];
        bit all_diff;
        bit tick_now;
        int ev, req;
        raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_left; raw[3] = btn_right;
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvl_prev[b] = 0; m_fill[b] = 0;
            end
            m_en_run = 0; m_pend_v = 0; m_pend_c = 0; m_dir = 3;
            exp_q.delete();
        end else begin
            ev = -1;
            for (int b = 3; b >= 0; b--) if (m_lvl[b] && !m_lvl_prev[b]) ev = b;
            tick_now = enable && (m_en_run % TD == TD - 1);
            m_en_run = enable ? m_en_run + 1 : 0;
            if (tick_now) begin
                req = (ev >= 0) ? ev : (m_pend_v ? m_pend_c : -1);
                if (req >= 0 && !opposite(req, m_dir)) m_dir = req;
                m_pend_v = 0;
                exp_q.push_back(m_dir);
            end else if (ev >= 0) begin
                m_pend_v = 1;
                m_pend_c = ev;
            end
            for (int b = 0; b < 4; b++) begin
                for (int j = DB - 1; j > 0; j--) m_win[b][j] = m_win[b][j-1];
                m_win[b][0] = m_s2[b];
                if (m_fill[b] < DB) m_fill[b]++;
                all_diff = (m_fill[b] >= DB);
                for (int j = 0; j < DB; j++) if (m_win[b][j] == m_lvl[b]) all_diff = 0;
                m_lvl_prev[b] = m_lvl[b];
                if (all_diff) m_lvl[b] = m_s2[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
    end

    // Monitor: every DUT tick must match a queued model tick and carry the queued direction.
    always @(negedge clk) begin
        int e;
        if (mon_on) begin
            if (move_tick || exp_q.size() != 0) begin
                check(move_tick && exp_q.size() > 0, "tick_align", int'(move_tick), exp_q.size());
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (move_tick) check(int'(dir) == e, "tick_dir", int'(dir), e);
                end
            end
            check(int'(dir) == m_dir, "dir_track", int'(dir), m_dir);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        check(dir == 2'b11, "reset_dir", int'(dir), 3);
        check(move_tick == 1'b0, "reset_tick", int'(move_tick), 0);
        reset = 1'b0;
    endtask

    task automatic set_btns(input logic [3:0] v);
        {btn_right, btn_left, btn_down, btn_up} = v;
    endtask

    task automatic press(input logic [3:0] v, input int hold, input int gap);
        set_btns(v);
        step(hold);
        set_btns(4'b0000);
        step(gap);
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!move_tick && cyc < 40);
        check(move_tick == 1'b1, "tick_timeout", int'(move_tick), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int r;
        reset = 1'b1; enable = 1'b0;
        set_btns(4'b0000);
        step(2);
        mon_on = 1'b1;

        // Free-running ticks from reset release
        enable = 1'b1;
        do_reset(2);
        for (int k = 0; k < 3; k++) begin
            wait_tick(cyc);
            check(cyc == TD, "tick_period", cyc, TD);
            check(dir == 2'b11, "idle_dir", int'(dir), 3);
        end

        // Bouncing UP produces nothing; a clean hold produces one press
        enable = 1'b0;
        do_reset(1);
        for (int k = 0; k < 10; k++) begin
            btn_up = ~btn_up;
            step(2);
        end
        btn_up = 1'b0;
        step(6);
        enable = 1'b1;
        wait_tick(cyc);
        check(dir == 2'b11, "bounce_dir", int'(dir), 3);
        enable = 1'b0;
        press(4'b0001, 10, 6);
        enable = 1'b1;
        wait_tick(cyc);
        check(cyc == TD, "reenable_period", cyc, TD);
        check(dir == 2'b00, "held_up_dir", int'(dir), 0);

        // LEFT against RIGHT is rejected and the request is consumed
        enable = 1'b0;
        do_reset(1);
        press(4'b0100, 8, 6);
        enable = 1'b1;
        wait_tick(cyc);
        check(dir == 2'b11, "reject_left", int'(dir), 3);
        wait_tick(cyc);
        check(dir == 2'b11, "pending_cleared", int'(dir), 3);

        // Last press wins, and simultaneous presses resolve by priority
        enable = 1'b0;
        do_reset(1);
        press(4'b0010, 8, 6);
        press(4'b0001, 8, 6);
        enable = 1'b1;
        wait_tick(cyc);
        check(dir == 2'b00, "last_wins", int'(dir), 0);
        enable = 1'b0;
        do_reset(1);
        press(4'b0101, 8, 6);
        enable = 1'b1;
        wait_tick(cyc);
        check(dir == 2'b00, "priority_up_left", int'(dir), 0);

        // Sweep press phase against the tick so one lands just before a commit edge
        for (int off = 0; off < TD; off++) begin
            enable = 1'b1;
            do_reset(1);
            step(off);
            press(4'b0001, 8, 0);
            wait_tick(cyc);
            check(dir == 2'b00, "phase_up", int'(dir), 0);
        end

        // Disabled timer keeps pending; mid-period reset discards it
        enable = 1'b1;
        do_reset(1);
        wait_tick(cyc);
        enable = 1'b0;
        press(4'b0010, 8, 12);
        enable = 1'b1;
        wait_tick(cyc);
        check(cyc == TD, "enable_first_tick", cyc, TD);
        check(dir == 2'b01, "enable_down", int'(dir), 1);
        enable = 1'b0;
        press(4'b0010, 8, 4);
        enable = 1'b1;
        step(3);
        do_reset(1);
        wait_tick(cyc);
        check(cyc == TD, "reset_counter", cyc, TD);
        check(dir == 2'b11, "reset_pending", int'(dir), 3);

        // Random traffic scored by the model
        enable = 1'b1;
        repeat (600) begin
            r = $urandom_range(0, 99);
            if (r < 3) do_reset($urandom_range(1, 2));
            else if (r < 13) enable = ~enable;
            set_btns(4'($urandom_range(0, 15)));
            step($urandom_range(1, 12));
        end
        set_btns(4'b0000);
        step(20);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required to accept a button level change; minimum 2.
REQ-002 Parameter TICK_DIV, default 25000000: CLK cycles per move period; minimum 2.
REQ-003 Port CLK  input  1  system clock; all state updates on its rising edge.
REQ-004 Port RESET  input  1  synchronous, active-high reset.
REQ-005 Port BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 Port ENABLE  input  1  game running; high lets the move timer run.
REQ-007 Port MOVE_TICK  output  1  one-cycle pulse: the downstream snake mover advances one cell.
REQ-008 Port DIR  output  2  committed direction: 00 up, 01 down, 10 left, 11 right.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each button SHALL have its own debounce counter and debounced level.
REQ-011 The debounced level SHALL take the synchronized value once that value has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
REQ-012 Any cycle in which the synchronized value equals the debounced level SHALL clear that button's counter.
REQ-013 A press event SHALL be a one-cycle 0->1 transition of a debounced level; a held button SHALL produce exactly one event.
REQ-014 Several press events in the same cycle SHALL resolve by priority UP > DOWN > LEFT > RIGHT; lower-priority events are dropped.
REQ-015 A 1-deep pending register (valid flag + 2-bit code) SHALL capture the resolved press event; a later event overwrites an earlier unconsumed one (last press wins).
REQ-016 While ENABLE=1, the tick counter SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-017 MOVE_TICK SHALL be 1 exactly in the cycle after the counter holds TICK_DIV-1, giving one pulse every TICK_DIV cycles.
REQ-018 While ENABLE=0, the tick counter SHALL be held at 0 and MOVE_TICK SHALL be 0; pending state and DIR are retained.
REQ-019 Commit: on the same edge that sets MOVE_TICK=1, DIR SHALL load the pending code if pending is valid and the code is not the opposite of the current DIR; downstream therefore sees the new DIR together with MOVE_TICK.
REQ-020 Opposite pairs SHALL be UP/DOWN and LEFT/RIGHT; a request equal to or opposite of DIR leaves DIR unchanged.
REQ-021 The pending valid flag SHALL clear on every commit edge, whether the request was accepted or rejected.
REQ-022 A press event in the cycle immediately preceding a commit edge SHALL bypass the pending register and be the request evaluated at that commit.
REQ-023 DIR SHALL change only on commit edges.

Reset
REQ-024 With RESET=1 at a clock edge, all of the following SHALL be loaded, overriding every other action including a mid-period tick or commit:
- DIR=11 (right)
- MOVE_TICK=0
- pending invalid
- tick counter 0
- debounce counters 0
- debounced levels 0
- synchronizers 0
REQ-025 After RESET deasserts with ENABLE=1, the first MOVE_TICK SHALL occur TICK_DIV cycles later.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-026 Reset, then ENABLE=1 -> DIR=11 throughout; MOVE_TICK pulses 1 cycle wide at cycles 8, 16, 24 after reset release.
REQ-027 BTN_UP toggles every 2 cycles for 20 cycles -> no press event and DIR stays 11; BTN_UP then held 10 cycles -> exactly one event, and DIR=00 at the next MOVE_TICK.
REQ-028 DIR=11, press LEFT between ticks -> DIR stays 11 at the next tick and pending is cleared; no press before the following tick -> DIR still 11.
REQ-029 DIR=11, press DOWN then UP within one period -> DIR=00 at the tick (last wins); UP and LEFT events in the same cycle -> DIR=00.
REQ-030 Press event in the cycle before the commit edge -> applied at that tick.
REQ-031 ENABLE=0 for 20 cycles with a pending DOWN -> no MOVE_TICK and DIR unchanged; on re-enable DIR=01 at the first tick, 8 cycles later. RESET asserted mid-period -> next cycle DIR=11, counter 0, pending invalid.
